stream_demux4: RTL and testbench

//   Four-way demultiplexer for a valid/ready stream; the distributing counterpart of the 4:1 mux.
//   A single input stream is routed to one of four output channels by a 2-bit select.
//   The select is sampled on the first beat of a packet and locked until the last beat.

---
 rtl/stream_demux4.sv | 58 +++++
 tb/tb_stream_demux4.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// stream_demux4: 1:4 valid/ready demultiplexer with per-packet channel lock and per-channel output registers
module stream_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic [1:0]         sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_last,
  output logic               busy,
  output logic [1:0]         cur_sel
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nxt;
  logic [1:0] lock, lock_nxt, t;
  logic acc;
  logic [WIDTH-1:0] data_q [4];
  always_comb begin
    t         = (state == PKT) ? lock : sel;
    in_ready  = !rst && (!out_valid[t] || out_ready[t]);
    acc       = in_valid && in_ready;
    state_nxt = acc ? (in_last ? IDLE : PKT) : state;
    lock_nxt  = (acc && state == IDLE) ? sel : lock;
    busy      = (state == PKT);
    cur_sel   = busy ? lock : 2'd0;
  end
  // a register refills on the same edge it drains, keeping 1 beat/cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock      <= '0;
      out_valid <= '0;
      out_last  <= '0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      state <= state_nxt;
      lock  <= lock_nxt;
      for (int k = 0; k < 4; k++) begin
        if (acc && t == 2'(k)) begin
          data_q[k]    <= in_data;
          out_last[k]  <= in_last;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end
endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4: vector table, directed reset sequence and randomized scoreboard check of stream_demux4
module tb_stream_demux4;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, in_last = 0;
  logic [7:0]  in_data = 0;
  logic [1:0]  sel = 0, cur_sel;
  logic [3:0]  out_valid, out_ready = 4'hF, out_last;
  logic [31:0] out_data;
  logic        busy;
  int n_chk = 0, n_fail = 0;

  stream_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic l; logic [1:0] s; logic [3:0] ordy;
    logic e_rdy; logic [3:0] e_ov; logic e_busy; logic [1:0] e_cs;
    logic [1:0] e_ch; logic [7:0] e_d; logic e_l;
  } vec_t;
  vec_t vt [13];

  // scoreboard: per-channel expected beats {last,data}
  logic [8:0] sb [4][0:2047];
  int wp [4], rp [4];
  int sent, cyc;
  logic have, first, p_l;
  logic [7:0] p_d;
  logic [1:0] p_s, pkt_dest;
  int pkt_left;
  logic [3:0] prev_stall;
  logic [7:0] prev_d [4];
  logic [3:0] prev_l;

  task automatic rnd_step(input logic drain);
    logic [3:0] sv, sr, sl;
    logic [31:0] sd;
    logic acc;
    logic [1:0] dest;
    @(negedge clk);
    if (!drain && !have && sent < 2000 && $urandom_range(0, 3) != 0) begin
      if (pkt_left == 0) begin
        pkt_left = $urandom_range(1, 8);
        if (pkt_left > 2000 - sent) pkt_left = 2000 - sent;
        first = 1;
      end
      p_d = 8'($urandom);
      p_s = 2'($urandom);
      p_l = (pkt_left == 1);
      have = 1;
    end
    in_valid  = have;
    in_data   = p_d;
    in_last   = p_l;
    sel       = p_s;
    out_ready = drain ? 4'hF : 4'($urandom);
    #1;
    sv = out_valid; sr = out_ready; sd = out_data; sl = out_last;
    acc = in_valid && in_ready;
    for (int k = 0; k < 4; k++) begin
      if (prev_stall[k]) begin
        chk($sformatf("stall_valid%0d", k), 32'(sv[k]), 32'd1);
        chk($sformatf("stall_data%0d", k), {23'd0, sl[k], sd[k*8 +: 8]}, {23'd0, prev_l[k], prev_d[k]});
      end
      prev_stall[k] = sv[k] && !sr[k];
      prev_d[k] = sd[k*8 +: 8];
      prev_l[k] = sl[k];
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (sv[k] && sr[k]) begin
        if (rp[k] >= wp[k]) chk($sformatf("extra_beat_ch%0d", k), 32'(rp[k]), 32'(wp[k] - 1));
        else begin
          chk($sformatf("sb_ch%0d", k), {23'd0, sl[k], sd[k*8 +: 8]}, 32'(sb[k][rp[k]]));
          rp[k]++;
        end
      end
    if (acc) begin
      if (first) pkt_dest = p_s;
      dest = pkt_dest;
      sb[dest][wp[dest]] = {p_l, p_d};
      wp[dest]++;
      first = 0;
      pkt_left--;
      have = 0;
      sent++;
    end
  endtask

  initial begin
    //        v  d     l  s  ordy  rdy ov      busy cs ch  d     l
    vt[0]  = '{1, 8'hA5, 1, 2, 4'hF, 1, 4'b0100, 0, 0, 2, 8'hA5, 1};
    vt[1]  = '{1, 8'h11, 0, 1, 4'hF, 1, 4'b0010, 1, 1, 1, 8'h11, 0};
    vt[2]  = '{1, 8'h22, 0, 3, 4'hF, 1, 4'b0010, 1, 1, 1, 8'h22, 0};
    vt[3]  = '{1, 8'h33, 1, 3, 4'hF, 1, 4'b0010, 0, 0, 1, 8'h33, 1};
    vt[4]  = '{0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 8'h00, 0};
    vt[5]  = '{1, 8'h01, 1, 0, 4'hE, 1, 4'b0001, 0, 0, 0, 8'h01, 1};
    vt[6]  = '{1, 8'h02, 1, 0, 4'hE, 0, 4'b0001, 0, 0, 0, 8'h01, 1};
    vt[7]  = '{1, 8'h02, 1, 0, 4'hF, 1, 4'b0001, 0, 0, 0, 8'h02, 1};
    vt[8]  = '{0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 8'h00, 0};
    vt[9]  = '{1, 8'h55, 1, 0, 4'hE, 1, 4'b0001, 0, 0, 0, 8'h55, 1};
    vt[10] = '{1, 8'h7E, 1, 3, 4'hE, 1, 4'b1001, 0, 0, 3, 8'h7E, 1};
    vt[11] = '{0, 8'h00, 0, 3, 4'h6, 0, 4'b1001, 0, 0, 0, 8'h55, 1};
    vt[12] = '{0, 8'h00, 0, 0, 4'hF, 1, 4'b0000, 0, 0, 0, 8'h00, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 0;

    foreach (vt[i]) begin
      @(negedge clk);
      in_valid = vt[i].v; in_data = vt[i].d; in_last = vt[i].l; sel = vt[i].s; out_ready = vt[i].ordy;
      #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_cur_sel", i), 32'(cur_sel), 32'(vt[i].e_cs));
      if (vt[i].e_ov[vt[i].e_ch])
        chk($sformatf("v%0d_ch%0d_beat", i, vt[i].e_ch),
            {23'd0, out_last[vt[i].e_ch], out_data[vt[i].e_ch*8 +: 8]}, {23'd0, vt[i].e_l, vt[i].e_d});
    end

    // reset in the middle of a 4-beat packet to ch1
    @(negedge clk);
    in_valid = 1; in_data = 8'hA1; in_last = 0; sel = 1; out_ready = 4'h0;
    @(negedge clk);
    in_data = 8'hA2; sel = 0; out_ready = 4'hF;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_cur_sel", 32'(cur_sel), 32'd1);
    rst = 1; in_data = 8'hA3;
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cur_sel", 32'(cur_sel), 32'd0);
    @(negedge clk);
    rst = 0; in_valid = 1; in_data = 8'hB1; in_last = 1; sel = 2; out_ready = 4'h0;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'b0100);
    chk("post_rst_ch2", 32'(out_data[23:16]), 32'hB1);
    @(negedge clk);
    in_valid = 0; out_ready = 4'hF;
    repeat (2) @(posedge clk);

    // randomized traffic against the per-channel scoreboard
    for (int k = 0; k < 4; k++) begin wp[k] = 0; rp[k] = 0; end
    sent = 0; cyc = 0; have = 0; first = 0; pkt_left = 0; pkt_dest = 0;
    p_d = 0; p_l = 0; p_s = 0; prev_stall = '0; prev_l = '0;
    for (int k = 0; k < 4; k++) prev_d[k] = '0;
    while (sent < 2000 && cyc < 40000) begin
      rnd_step(1'b0);
      cyc++;
    end
    chk("random_beats_sent", 32'(sent), 32'd2000);
    repeat (6) rnd_step(1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("sb_drained_ch%0d", k), 32'(rp[k]), 32'(wp[k]));
    chk("random_final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
